// File: rtl/bool_lut_pkg.sv
// Shared types and helpers for the boolean LUT sweep unit.
package bool_lut_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/bool_lut_core.sv
// Combinational truth-table lookup: selects tt[idx] as the function value.
module bool_lut_core
    import bool_lut_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [tt_width(N_IN)-1:0] i_tt,
    input  logic [N_IN-1:0]           i_idx,
    output logic                      o_f
);

    assign o_f = i_tt[i_idx];

endmodule

// File: rtl/bool_lut_sweep.sv
// N-input boolean function unit with per-vector eval and exhaustive sweep.
// Optional table self-check enabled by defining BOOL_LUT_SELFCHECK_EN.
//
//   state | meaning
//   IDLE  | accepts eval requests, table loads and sweep_start
//   SWEEP | pushes tt[0..TT_W-1] into the output slot, counting ones
//   DONE  | publishes the ones count, pulses sweep_done, returns to IDLE
module bool_lut_sweep
    import bool_lut_pkg::*;
#(
    parameter int                     N_IN     = 3,
    parameter logic [(2**N_IN)-1:0]   TT_RESET = 8'hED
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_IN-1:0]           in_vec,
    input  logic                      tt_wr_en,
    input  logic [tt_width(N_IN)-1:0] tt_wr_data,
    input  logic                      sweep_start,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_f,
    output logic [N_IN-1:0]           out_idx,
    output logic                      busy,
    output logic                      sweep_done,
    output logic [N_IN:0]             ones_count
`ifdef BOOL_LUT_SELFCHECK_EN
    ,
    input  logic [tt_width(N_IN)-1:0] exp_tt,
    output logic [N_IN:0]             mismatch_cnt,
    output logic                      sweep_err
`endif
);

    localparam int            TT_W     = tt_width(N_IN);
    localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(TT_W - 1);

    state_t            r_state;
    logic [TT_W-1:0]   r_tt;
    logic [N_IN:0]     r_idx;
    logic [N_IN:0]     r_acc;
    logic              r_out_valid;
    logic              r_out_f;
    logic [N_IN-1:0]   r_out_idx;
    logic              r_sweep_done;
    logic [N_IN:0]     r_ones_count;

    logic              w_slot_free;
    logic              w_in_ready;
    logic [N_IN-1:0]   w_idx;
    logic              w_f;

    assign w_slot_free = !r_out_valid || out_ready;
    // sweep_start wins over a concurrent eval request
    assign w_in_ready  = (r_state == IDLE) && w_slot_free && !sweep_start;
    assign w_idx       = (r_state == SWEEP) ? r_idx[N_IN-1:0] : in_vec;

    bool_lut_core #(.N_IN(N_IN)) u_core (
        .i_tt  (r_tt),
        .i_idx (w_idx),
        .o_f   (w_f)
    );

`ifdef BOOL_LUT_SELFCHECK_EN
    logic [N_IN:0] r_mis_acc;
    logic [N_IN:0] r_mismatch_cnt;
    logic          r_sweep_err;
    logic          w_exp_bit;

    assign w_exp_bit    = exp_tt[w_idx];
    assign mismatch_cnt = r_mismatch_cnt;
    assign sweep_err    = r_sweep_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tt         <= TT_RESET;
            r_idx        <= '0;
            r_acc        <= '0;
            r_out_valid  <= 1'b0;
            r_out_f      <= 1'b0;
            r_out_idx    <= '0;
            r_sweep_done <= 1'b0;
            r_ones_count <= '0;
`ifdef BOOL_LUT_SELFCHECK_EN
            r_mis_acc      <= '0;
            r_mismatch_cnt <= '0;
            r_sweep_err    <= 1'b0;
`endif
        end else begin
            r_sweep_done <= 1'b0;
            if (w_slot_free) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (tt_wr_en) begin
                        r_tt <= tt_wr_data;
                    end
                    if (sweep_start) begin
                        r_state <= SWEEP;
                        r_idx   <= '0;
                        r_acc   <= '0;
`ifdef BOOL_LUT_SELFCHECK_EN
                        r_mis_acc <= '0;
`endif
                    end else if (in_valid && w_in_ready) begin
                        r_out_valid <= 1'b1;
                        r_out_f     <= w_f;
                        r_out_idx   <= in_vec;
                    end
                end
                SWEEP: begin
                    if (w_slot_free) begin
                        r_out_valid <= 1'b1;
                        r_out_f     <= w_f;
                        r_out_idx   <= r_idx[N_IN-1:0];
                        r_acc       <= r_acc + (N_IN+1)'(w_f);
                        r_idx       <= r_idx + (N_IN+1)'(1);
`ifdef BOOL_LUT_SELFCHECK_EN
                        r_mis_acc   <= r_mis_acc + (N_IN+1)'(w_f != w_exp_bit);
`endif
                        if (r_idx == LAST_IDX) begin
                            r_state      <= DONE;
                            r_sweep_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_ones_count <= r_acc;
`ifdef BOOL_LUT_SELFCHECK_EN
                    r_mismatch_cnt <= r_mis_acc;
                    r_sweep_err    <= (r_mis_acc != '0);
`endif
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_f      = r_out_f;
    assign out_idx    = r_out_idx;
    assign busy       = (r_state == SWEEP);
    assign sweep_done = r_sweep_done;
    assign ones_count = r_ones_count;

endmodule

// File: tb/tb_bool_lut_sweep.sv
// Randomised self-checking bench for bool_lut_sweep against a transaction-level model.
// Covers the self-check ports when BOOL_LUT_SELFCHECK_EN is defined.
module tb_bool_lut_sweep;

    localparam int N  = 3;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_vec = '0;
    logic          tt_wr_en = 1'b0;
    logic [TW-1:0] tt_wr_data = '0;
    logic          sweep_start = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_f;
    logic [N-1:0]  out_idx;
    logic          busy;
    logic          sweep_done;
    logic [N:0]    ones_count;
    logic [TW-1:0] exp_tt = 8'hED;
`ifdef BOOL_LUT_SELFCHECK_EN
    logic [N:0]    mismatch_cnt;
    logic          sweep_err;
`endif

    always #5 clk = ~clk;

    bool_lut_sweep #(.N_IN(N), .TT_RESET(8'hED)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .tt_wr_en    (tt_wr_en),
        .tt_wr_data  (tt_wr_data),
        .sweep_start (sweep_start),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_f       (out_f),
        .out_idx     (out_idx),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .ones_count  (ones_count)
`ifdef BOOL_LUT_SELFCHECK_EN
        ,
        .exp_tt       (exp_tt),
        .mismatch_cnt (mismatch_cnt),
        .sweep_err    (sweep_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: mode 0=idle, 1=sweeping, 2=publishing result
    int            m_mode = 0;
    logic [TW-1:0] m_tt = 8'hED;
    bit            m_slot_v = 0;
    logic          m_f = 0;
    logic [N-1:0]  m_idx = '0;
    int            m_sidx = 0;
    int            m_ones = 0;
    int            m_mis = 0;
    bit            m_done = 0;
    int            m_done_total = 0;
    int            dut_done_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(output bit exp_rdy);
        bit            free;
        logic [TW-1:0] tt_old;
        exp_rdy = 0;
        if (rst) begin
            m_mode = 0; m_tt = 8'hED; m_slot_v = 0; m_f = 0; m_idx = '0;
            m_sidx = 0; m_ones = 0; m_mis = 0; m_done = 0;
            return;
        end
        free    = !m_slot_v || out_ready;
        exp_rdy = (m_mode == 0) && free && !sweep_start;
        m_done  = 0;
        if (free) m_slot_v = 0;
        case (m_mode)
            0: begin
                tt_old = m_tt;
                if (tt_wr_en) m_tt = tt_wr_data;
                if (sweep_start) begin
                    m_mode = 1;
                    m_sidx = 0;
                end else if (in_valid && exp_rdy) begin
                    m_slot_v = 1;
                    m_f      = tt_old[in_vec];
                    m_idx    = in_vec;
                end
            end
            1: if (free) begin
                m_slot_v = 1;
                m_f      = m_tt[m_sidx];
                m_idx    = N'(m_sidx);
                if (m_sidx == TW - 1) begin
                    m_mode = 2;
                    m_done = 1;
                    m_done_total++;
                end
                m_sidx++;
            end
            default: begin
                m_ones = $countones(m_tt);
                m_mis  = $countones(m_tt ^ exp_tt);
                m_mode = 0;
            end
        endcase
    endtask

    // One clock: check in_ready before the edge, advance the model, check all outputs after it.
    task automatic cycle();
        bit er;
        bit was_rst;
        #1;
        was_rst = rst;
        model_step(er);
        if (!was_rst) chk("in_ready", 32'(in_ready), 32'(er));
        @(posedge clk);
        #1;
        if (sweep_done) dut_done_total++;
        chk("out_valid", 32'(out_valid), 32'(m_slot_v));
        chk("out_f", 32'(out_f), 32'(m_f));
        chk("out_idx", 32'(out_idx), 32'(m_idx));
        chk("busy", 32'(busy), 32'(m_mode == 1));
        chk("sweep_done", 32'(sweep_done), 32'(m_done));
        chk("ones_count", 32'(ones_count), 32'(m_ones));
`ifdef BOOL_LUT_SELFCHECK_EN
        chk("mismatch_cnt", 32'(mismatch_cnt), 32'(m_mis));
        chk("sweep_err", 32'(sweep_err), 32'(m_mis != 0));
`endif
    endtask

    task automatic run_to_idle(input int budget);
        int n = 0;
        while (m_mode != 0 && n < budget) begin
            cycle();
            n++;
        end
        if (m_mode != 0) begin
            errors++;
            $display("FAIL sweep_timeout actual=busy required=idle within %0d cycles", budget);
        end
    endtask

    task automatic do_sweep();
        sweep_start = 1'b1;
        cycle();
        sweep_start = 1'b0;
        run_to_idle(40);
        cycle();
    endtask

    initial begin
        logic [TW-1:0] seq_got;
        logic [TW-1:0] seq_req;
        int            d0;

        // Reset
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ones_count", 32'(ones_count), 0);

        // Evaluate 1 and 3 with the reset table
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 3'd1;
        cycle();
        chk("eval1_f", 32'(out_f), 0);
        chk("eval1_idx", 32'(out_idx), 1);
        in_vec = 3'd3;
        cycle();
        chk("eval3_f", 32'(out_f), 1);
        chk("eval3_idx", 32'(out_idx), 3);
        in_valid = 1'b0;
        cycle();

        // Backpressure holds the result
        in_valid  = 1'b1;
        in_vec    = 3'd5;
        out_ready = 1'b0;
        cycle();
        in_vec = 3'd2;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_f", 32'(out_f), 1);
            chk("bp_idx", 32'(out_idx), 5);
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 1);
        cycle();
        in_valid = 1'b0;
        cycle();

        // Table load, then a load attempted mid-sweep
        tt_wr_en   = 1'b1;
        tt_wr_data = 8'h96;
        cycle();
        tt_wr_en = 1'b0;
        in_valid = 1'b1;
        in_vec   = 3'd7;
        cycle();
        chk("tt96_f7", 32'(out_f), 1);
        in_vec = 3'd6;
        cycle();
        chk("tt96_f6", 32'(out_f), 0);
        in_valid    = 1'b0;
        sweep_start = 1'b1;
        cycle();
        sweep_start = 1'b0;
        tt_wr_en    = 1'b1;
        tt_wr_data  = 8'h00;
        cycle();
        tt_wr_en = 1'b0;
        run_to_idle(40);
        cycle();
        chk("tt96_sweep_ones", 32'(ones_count), 4);

        tt_wr_en   = 1'b1;
        tt_wr_data = 8'hED;
        cycle();
        tt_wr_en = 1'b0;

        // Full sweep of the default function
        d0      = dut_done_total;
        seq_got = '0;
        seq_req = 8'hED;
        sweep_start = 1'b1;
        cycle();
        sweep_start = 1'b0;
        for (int i = 0; i < 40 && m_mode != 0; i++) begin
            cycle();
            if (out_valid) seq_got[out_idx] = out_f;
        end
        cycle();
        chk("sweep_seq", 32'(seq_got), 32'(seq_req));
        chk("sweep_done_pulses", 32'(dut_done_total - d0), 1);
        chk("sweep_ones", 32'(ones_count), 6);

        // Reset mid-sweep under toggling backpressure
        tt_wr_en   = 1'b1;
        tt_wr_data = 8'h0F;
        cycle();
        tt_wr_en    = 1'b0;
        d0          = dut_done_total;
        sweep_start = 1'b1;
        cycle();
        sweep_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_mode == 1 && m_sidx == 4) break;
            out_ready = ~out_ready;
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ones", 32'(ones_count), 0);
        cycle();
        chk("midrst_no_done", 32'(dut_done_total - d0), 0);
        do_sweep();
        chk("postrst_ones", 32'(ones_count), 6);

`ifdef BOOL_LUT_SELFCHECK_EN
        exp_tt = 8'hEC;
        do_sweep();
        chk("sc_mis_one", 32'(mismatch_cnt), 1);
        chk("sc_err_one", 32'(sweep_err), 1);
        exp_tt = 8'hED;
        do_sweep();
        chk("sc_mis_zero", 32'(mismatch_cnt), 0);
        chk("sc_err_zero", 32'(sweep_err), 0);
`endif

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            in_valid    = ($urandom_range(0, 1) == 1);
            in_vec      = N'($urandom_range(0, 7));
            out_ready   = ($urandom_range(0, 3) != 0);
            tt_wr_en    = ($urandom_range(0, 15) == 0);
            tt_wr_data  = 8'($urandom_range(0, 255));
            sweep_start = ($urandom_range(0, 29) == 0);
            if (m_mode == 0 && $urandom_range(0, 9) == 0) exp_tt = 8'($urandom_range(0, 255));
            cycle();
        end
        rst = 1'b0;
        sweep_start = 1'b0;
        tt_wr_en = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        run_to_idle(40);
        cycle();
        chk("done_total", 32'(dut_done_total), 32'(m_done_total));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
